// File: rtl/project_types.sv
// Shared types for the memory arbiter: FSM state encoding,
// default timeout and an index-width helper.
package project_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int MEM_ARB_TIMEOUT_DEFAULT = 15;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Request picker: scans the request vector starting at a given
// index (wrapping) and returns the first requester as one-hot and index.
module arb_pick
    import project_types::*;
#(
    parameter int NUM = 2,
    parameter int IW  = idx_width(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  start,
    output logic [NUM-1:0] grant_oh,
    output logic [IW-1:0]  grant_idx,
    output logic           valid
);

    int j;

    // first requester at or after start, wrapping around
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        valid     = 1'b0;
        j         = 0;
        for (int i = 0; i < NUM; i++) begin
            j = (int'(start) + i) % NUM;
            if (!valid && req[j]) begin
                valid       = 1'b1;
                grant_oh[j] = 1'b1;
                grant_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-master to single-slave memory bus arbiter with ack timeout.
// Define MEM_ARB_RR_EN for round-robin; default is fixed priority.
module mem_arbiter
    import project_types::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = MEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_sel_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata_i,
    output logic [DATA_W-1:0]                 m_rdata_o,
    output logic [NUM_MASTERS-1:0]            m_done_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            stallreq_o,
    output logic                              s_ce_o,
    output logic                              s_we_o,
    output logic [DATA_W/8-1:0]               s_sel_o,
    output logic [ADDR_W-1:0]                 s_addr_o,
    output logic [DATA_W-1:0]                 s_wdata_o,
    input  logic [DATA_W-1:0]                 s_rdata_i,
    input  logic                              s_ack_i
);

    localparam int SW = DATA_W / 8;
    localparam int IW = idx_width(NUM_MASTERS);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_t state, state_nx;

    logic [IW-1:0]          grant;
    logic [IW-1:0]          start;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;

    logic              we_mux;
    logic [SW-1:0]     sel_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    logic              we_q;
    logic [SW-1:0]     sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        cnt;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              timeout;

    assign timeout = (cnt >= TO_LAST);

`ifdef MEM_ARB_RR_EN
    logic [IW-1:0] ptr;

    // round-robin pointer moves past the master just completed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (state == DONE)
            ptr <= (grant == IW'(NUM_MASTERS - 1)) ? '0 : grant + IW'(1);
    end

    assign start = ptr;
`else
    assign start = '0;
`endif

    arb_pick #(
        .NUM (NUM_MASTERS),
        .IW  (IW)
    ) u_pick (
        .req       (m_req_i),
        .start     (start),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    // select the picked master's request fields
    always_comb begin
        we_mux    = 1'b0;
        sel_mux   = '0;
        addr_mux  = '0;
        wdata_mux = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_oh[i]) begin
                we_mux    = we_mux | m_we_i[i];
                sel_mux   = sel_mux | m_sel_i[i*SW +: SW];
                addr_mux  = addr_mux | m_addr_i[i*ADDR_W +: ADDR_W];
                wdata_mux = wdata_mux | m_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pick_valid) state_nx = BUSY;
            BUSY:    if (s_ack_i || timeout) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // request latch, wait counter and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant   <= pick_idx;
                        we_q    <= we_mux;
                        sel_q   <= sel_mux;
                        addr_q  <= addr_mux;
                        wdata_q <= wdata_mux;
                        cnt     <= '0;
                        err_q   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (s_ack_i) begin
                        rdata_q <= s_rdata_i;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_rdata_o  = rdata_q;
    assign stallreq_o = m_req_i & ~m_done_o;

    // slave bus and completion pulses decoded from state
    always_comb begin
        s_ce_o    = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        m_done_o  = '0;
        m_err_o   = '0;
        if (state == BUSY) begin
            s_ce_o    = 1'b1;
            s_we_o    = we_q;
            s_sel_o   = sel_q;
            s_addr_o  = addr_q;
            s_wdata_o = wdata_q;
        end
        if (state == DONE) begin
            m_done_o = NUM_MASTERS'(1) << grant;
            if (err_q)
                m_err_o = NUM_MASTERS'(1) << grant;
        end
    end

endmodule
